frame_ram_writer: RTL and testbench
===================================

Name: frame_ram_writer

Overview:
- Upstream neighbour of the burst TX sequencer: fills the external Triple-RAM (Red, Green, Blue) before it is read out.
- Accepts a stream of 24-bit RGB pixels over a valid/ready handshake in the wr_clk domain.
- Packs 4 consecutive pixels per channel into 32-bit words and writes them to the three RAMs at a shared, incrementing address.
- Asserts img_complete once the whole frame is stored.

Parameters:
- RAM_ADDR_WIDTH, 14, RAM word address width = $clog2(PIXEL_COUNT/4).
- RAM_DATA_WIDTH, 32, RAM word width: 4 pixels of 8 bits per channel.
- PIXEL_COUNT, 65536, pixels per frame; must be a multiple of 4 and ≥ 8.

Ports:
- wr_clk  in  1  clock (RAM write domain).
- rst_n  in  1  reset, asynchronous, active-low.
- frame_start  in  1  RGF pulse: begin or restart frame capture.
- pix_valid  in  1  input pixel valid.
- pix_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}.
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready.
- red_RAM_wdata  out  RAM_DATA_WIDTH  packed red word.
- green_RAM_wdata  out  RAM_DATA_WIDTH  packed green word.
- blue_RAM_wdata  out  RAM_DATA_WIDTH  packed blue word.
- RAM_waddr  out  RAM_ADDR_WIDTH  shared write address for all three RAMs.
- RAM_write_en  out  1  write strobe for all three RAMs.
- img_complete  out  1  frame fully written (level).
- frame_overrun  out  1  sticky: pix_valid seen while not capturing.
- pixels_written  out  $clog2(PIXEL_COUNT)+1  number of pixels committed to RAM.

Behaviour:
- Reset: state IDLE; every output 0 (pix_ready, wdata, waddr, write_en, img_complete, frame_overrun, pixels_written). Internal accumulators and counters are also 0.
- States:
  - IDLE: pix_ready=0. frame_start -> CAPTURE.
  - CAPTURE: pix_ready = ~frame_start (combinational).
  - DONE: pix_ready=0; img_complete=1.
- frame_start, accepted in any state, same edge:
  - Clears lane_idx, word_cnt, pixels_written, img_complete and frame_overrun.
  - Discards any partial word; enters CAPTURE.
  - A pixel presented in the same cycle is NOT accepted (pix_ready=0 that cycle).
- Packing:
  - lane_idx (2 bits) selects the byte lane; pixel k of a word goes to bits [8k+7:8k] of each channel. Red takes pix_data[23:16], green [15:8], blue [7:0].
  - Lanes 0-2 are stored in 24-bit per-channel accumulators.
  - On acceptance with lane_idx==3, the output registers load {pix byte, acc[23:0]} per channel, RAM_waddr <= word_cnt, and RAM_write_en=1 for exactly the next cycle.
  - Same edge: word_cnt++, lane_idx wraps to 0, pixels_written += 4.
- Latency: write strobe appears 1 cycle after the 4th pixel handshake.
- Throughput: 1 pixel/cycle sustained, no bubbles. Accumulators refill while the output registers hold the previous word.
- Held values: wdata and waddr hold their last values when write_en=0. write_en is a single-cycle pulse per word, never back-to-back closer than 4 cycles.
- Frame end: acceptance of pixel PIXEL_COUNT-1 (word_cnt == PIXEL_COUNT/4-1, lane 3) moves state to DONE on the same edge. img_complete rises on that edge, i.e. coincident with the final RAM_write_en cycle, and stays high until frame_start or reset.
- frame_overrun: set on any cycle with pix_valid=1 and state != CAPTURE, excluding the frame_start cycle. Sticky until frame_start or reset. No RAM write occurs.
- Abort: frame_start during CAPTURE drops the partial word (no write). Addressing restarts at 0; previously written words are overwritten by the new frame.
- Widths: word_cnt is $clog2(PIXEL_COUNT/4+1) bits; RAM_waddr takes its low RAM_ADDR_WIDTH bits; no wrap inside a frame.
- Reset mid-operation: asynchronous return to the reset values above; a write in flight is suppressed (write_en forced to 0).

Decomposition:
- Shared package sequencer_pkg:
  - typedef rgb_pixel_t (packed struct r,g,b 8-bit each).
  - enum writer_state_t {IDLE, CAPTURE, DONE}.
  - localparam PIX_PER_WORD=4.
- Sub-module pixel_word_packer: holds lane_idx, the three accumulators, and the output word registers. It emits a word_valid pulse to the parent FSM and address counter.

Test Plan:
- PIXEL_COUNT=16, frame_start, then 16 back-to-back pixels pix_i={i, 8'h40+i, 8'h80+i} -> 4 write_en pulses at addr 0..3. Word 0: red=32'h03020100, green=32'h43424140, blue=32'h83828180. Each pulse lands 1 cycle after its 4th pixel; img_complete rises with the 4th pulse; pixels_written=16.
- Same frame with random pix_valid bubbles (~50%) -> identical RAM contents and addresses; write_en still a single-cycle pulse per word.
- Abort after 6 pixels (word 0 written, 2 in partial), then frame_start plus 16 new pixels -> partial never written, first new write at addr 0, pixels_written resets to 0 and ends at 16.
- pix_valid=1 while in DONE, and in the same cycle as frame_start -> pix_ready=0, no write. DONE case sets frame_overrun=1; frame_start cycle does not set it; the next frame_start clears it.
- rst_n asserted for 1 cycle mid-capture, after 10 pixels -> all outputs 0 immediately, state IDLE, pix_ready=0 until frame_start; the new frame writes from addr 0.
- Default PIXEL_COUNT=65536, continuous stream -> 16384 writes, last at addr 16383 (14'h3FFF), img_complete=1, pixels_written=65536 (17-bit).

Source files
------------

// File: rtl/sequencer_pkg.sv
// Shared types for the frame RAM writer and its neighbours in the burst TX path.
//   rgb_pixel_t    : one 24-bit pixel, red in the top byte, blue in the bottom byte
//   writer_state_t : capture FSM states of frame_ram_writer
//   PIX_PER_WORD   : pixels packed into one RAM word per colour channel
package sequencer_pkg;

  localparam int PIX_PER_WORD = 4;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pixel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } writer_state_t;

endpackage

// File: rtl/frame_ram_writer_if.sv
// Pixel stream plus Triple-RAM write bus of the frame RAM writer.
//   pix_valid/pix_data/pix_ready : upstream pixel handshake
//   red/green/blue_RAM_wdata      : packed words, one per colour RAM
//   RAM_waddr/RAM_write_en        : address and strobe shared by all three RAMs
// Modports:
//   master : pixel source / RAM-side observer
//   slave  : the writer itself
interface frame_ram_writer_if #(
  parameter int RAM_ADDR_WIDTH = 14,
  parameter int RAM_DATA_WIDTH = 32
);
  import sequencer_pkg::*;

  logic                      pix_valid;
  rgb_pixel_t                pix_data;
  logic                      pix_ready;
  logic [RAM_DATA_WIDTH-1:0] red_RAM_wdata;
  logic [RAM_DATA_WIDTH-1:0] green_RAM_wdata;
  logic [RAM_DATA_WIDTH-1:0] blue_RAM_wdata;
  logic [RAM_ADDR_WIDTH-1:0] RAM_waddr;
  logic                      RAM_write_en;

  modport master (
    output pix_valid, pix_data,
    input  pix_ready,
    input  red_RAM_wdata, green_RAM_wdata, blue_RAM_wdata,
    input  RAM_waddr, RAM_write_en
  );

  modport slave (
    input  pix_valid, pix_data,
    output pix_ready,
    output red_RAM_wdata, green_RAM_wdata, blue_RAM_wdata,
    output RAM_waddr, RAM_write_en
  );

endinterface

// File: rtl/pixel_word_packer.sv
// Packs accepted pixels, four per word, into red/green/blue RAM words.
//   wr_clk, rst_n     : clock, asynchronous active-low reset
//   clear_i           : frame (re)start, drops any partial word
//   accept_i          : a pixel is being accepted this cycle
//   pix_i             : the accepted pixel
//   word_valid_o      : combinational, the accepted pixel completes a word
//   write_en_o        : registered write strobe, one cycle after word_valid_o
//   red/green/blue_word_o : packed words, held between strobes
module pixel_word_packer
  import sequencer_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 32
) (
  input  logic                      wr_clk,
  input  logic                      rst_n,
  input  logic                      clear_i,
  input  logic                      accept_i,
  input  rgb_pixel_t                pix_i,
  output logic                      word_valid_o,
  output logic                      write_en_o,
  output logic [RAM_DATA_WIDTH-1:0] red_word_o,
  output logic [RAM_DATA_WIDTH-1:0] green_word_o,
  output logic [RAM_DATA_WIDTH-1:0] blue_word_o
);

  // Lanes 0..2 live in the accumulators; lane 3 goes straight into the word.
  localparam int ACC_W = RAM_DATA_WIDTH - 8;

  logic [1:0]                lane_q, lane_d;
  logic [ACC_W-1:0]          red_acc_q, red_acc_d;
  logic [ACC_W-1:0]          green_acc_q, green_acc_d;
  logic [ACC_W-1:0]          blue_acc_q, blue_acc_d;
  logic [RAM_DATA_WIDTH-1:0] red_word_q, red_word_d;
  logic [RAM_DATA_WIDTH-1:0] green_word_q, green_word_d;
  logic [RAM_DATA_WIDTH-1:0] blue_word_q, blue_word_d;
  logic                      write_en_q;

  assign word_valid_o = accept_i && !clear_i && (lane_q == 2'd3);

  always_comb begin
    lane_d       = lane_q;
    red_acc_d    = red_acc_q;
    green_acc_d  = green_acc_q;
    blue_acc_d   = blue_acc_q;
    red_word_d   = red_word_q;
    green_word_d = green_word_q;
    blue_word_d  = blue_word_q;
    if (clear_i) begin
      lane_d      = '0;
      red_acc_d   = '0;
      green_acc_d = '0;
      blue_acc_d  = '0;
    end else if (accept_i) begin
      if (lane_q == 2'd3) begin
        // Output words reload while the accumulators start the next word.
        red_word_d   = {pix_i.r, red_acc_q};
        green_word_d = {pix_i.g, green_acc_q};
        blue_word_d  = {pix_i.b, blue_acc_q};
        lane_d       = '0;
      end else begin
        red_acc_d[{lane_q, 3'b000} +: 8]   = pix_i.r;
        green_acc_d[{lane_q, 3'b000} +: 8] = pix_i.g;
        blue_acc_d[{lane_q, 3'b000} +: 8]  = pix_i.b;
        lane_d                             = lane_q + 2'd1;
      end
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q       <= '0;
      red_acc_q    <= '0;
      green_acc_q  <= '0;
      blue_acc_q   <= '0;
      red_word_q   <= '0;
      green_word_q <= '0;
      blue_word_q  <= '0;
      write_en_q   <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      red_acc_q    <= red_acc_d;
      green_acc_q  <= green_acc_d;
      blue_acc_q   <= blue_acc_d;
      red_word_q   <= red_word_d;
      green_word_q <= green_word_d;
      blue_word_q  <= blue_word_d;
      write_en_q   <= word_valid_o;
    end
  end

  assign write_en_o   = write_en_q;
  assign red_word_o   = red_word_q;
  assign green_word_o = green_word_q;
  assign blue_word_o  = blue_word_q;

endmodule

// File: rtl/frame_ram_writer.sv
// Fills the external Triple-RAM with one frame of RGB pixels.
//   wr_clk, rst_n  : RAM write clock, asynchronous active-low reset
//   frame_start    : pulse, begin or restart frame capture
//   ram_if         : pixel handshake in, packed RAM write bus out (slave side)
//   img_complete   : level, whole frame stored
//   frame_overrun  : sticky, a pixel was offered while not capturing
//   pixels_written : pixels committed to RAM in the current frame
module frame_ram_writer
  import sequencer_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 14,
  parameter int RAM_DATA_WIDTH = 32,
  parameter int PIXEL_COUNT    = 65536
) (
  input  logic                           wr_clk,
  input  logic                           rst_n,
  input  logic                           frame_start,
  frame_ram_writer_if.slave              ram_if,
  output logic                           img_complete,
  output logic                           frame_overrun,
  output logic [$clog2(PIXEL_COUNT):0]   pixels_written
);

  localparam int WORDS  = PIXEL_COUNT / PIX_PER_WORD;
  localparam int WCNT_W = $clog2(WORDS + 1);
  localparam int PW_W   = $clog2(PIXEL_COUNT) + 1;

  writer_state_t             state_q, state_d;
  logic [WCNT_W-1:0]         word_cnt_q, word_cnt_d;
  logic [PW_W-1:0]           pix_cnt_q, pix_cnt_d;
  logic [RAM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                      overrun_q, overrun_d;
  logic                      pix_ready;
  logic                      accept;
  logic                      word_valid;
  logic                      write_en;
  logic                      last_word;

  assign accept    = ram_if.pix_valid && pix_ready;
  assign last_word = word_valid && (word_cnt_q == WCNT_W'(WORDS - 1));

  pixel_word_packer #(
    .RAM_DATA_WIDTH(RAM_DATA_WIDTH)
  ) u_packer (
    .wr_clk      (wr_clk),
    .rst_n       (rst_n),
    .clear_i     (frame_start),
    .accept_i    (accept),
    .pix_i       (ram_if.pix_data),
    .word_valid_o(word_valid),
    .write_en_o  (write_en),
    .red_word_o  (ram_if.red_RAM_wdata),
    .green_word_o(ram_if.green_RAM_wdata),
    .blue_word_o (ram_if.blue_RAM_wdata)
  );

  // Capture FSM; frame_start wins from any state and blocks acceptance that
  // cycle so the restart never mixes in a pixel from the old frame.
  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    case (state_q)
      IDLE: ;
      CAPTURE: begin
        pix_ready = !frame_start;
        if (last_word) state_d = DONE;
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    if (frame_start) state_d = CAPTURE;
  end

  // Word/pixel counters, write address and overrun flag. The address is taken
  // from the word counter at the moment a word completes, so it stays paired
  // with the data that loads on the same edge.
  always_comb begin
    word_cnt_d = word_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    waddr_d    = waddr_q;
    overrun_d  = overrun_q;
    if (frame_start) begin
      word_cnt_d = '0;
      pix_cnt_d  = '0;
      overrun_d  = 1'b0;
    end else begin
      if (word_valid) begin
        waddr_d    = word_cnt_q[RAM_ADDR_WIDTH-1:0];
        word_cnt_d = word_cnt_q + WCNT_W'(1);
        pix_cnt_d  = pix_cnt_q + PW_W'(PIX_PER_WORD);
      end
      if (ram_if.pix_valid && (state_q != CAPTURE)) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      pix_cnt_q  <= '0;
      waddr_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      waddr_q    <= waddr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign ram_if.pix_ready    = pix_ready;
  assign ram_if.RAM_waddr    = waddr_q;
  assign ram_if.RAM_write_en = write_en;
  assign img_complete        = (state_q == DONE);
  assign frame_overrun       = overrun_q;
  assign pixels_written      = pix_cnt_q;

endmodule

// File: tb/tb_frame_ram_writer.sv
// Self-checking bench for frame_ram_writer: a 16-pixel instance for the
// detailed scenarios and a 4096-pixel instance for a long continuous frame.
module tb_frame_ram_writer;
  import sequencer_pkg::*;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
    logic        done;
  } wr_t;

  logic        wr_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frameStart = 1'b0;
  logic        bigFrameStart = 1'b0;
  logic        imgComplete, frameOverrun;
  logic [4:0]  pixelsWritten;
  logic        bigImgComplete, bigFrameOverrun;
  logic [12:0] bigPixelsWritten;

  int totalChecks = 0;
  int passedChecks = 0;
  int cyc = 0;

  rgb_pixel_t sentQ[$];
  int         hsCyc[$];
  wr_t        obsQ[$];
  rgb_pixel_t bigSentQ[$];
  wr_t        bigObsQ[$];

  frame_ram_writer_if #(.RAM_ADDR_WIDTH(2), .RAM_DATA_WIDTH(32)) sIf ();
  frame_ram_writer_if #(.RAM_ADDR_WIDTH(10), .RAM_DATA_WIDTH(32)) bIf ();

  frame_ram_writer #(
    .RAM_ADDR_WIDTH(2), .RAM_DATA_WIDTH(32), .PIXEL_COUNT(16)
  ) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .frame_start(frameStart), .ram_if(sIf),
    .img_complete(imgComplete), .frame_overrun(frameOverrun),
    .pixels_written(pixelsWritten)
  );

  frame_ram_writer #(
    .RAM_ADDR_WIDTH(10), .RAM_DATA_WIDTH(32), .PIXEL_COUNT(4096)
  ) bigDut (
    .wr_clk(wr_clk), .rst_n(rst_n), .frame_start(bigFrameStart), .ram_if(bIf),
    .img_complete(bigImgComplete), .frame_overrun(bigFrameOverrun),
    .pixels_written(bigPixelsWritten)
  );

  always #5 wr_clk = ~wr_clk;

  always @(posedge wr_clk) cyc <= cyc + 1;

  // RAM-side monitors: every write strobe seen is logged with its cycle.
  always @(negedge wr_clk) begin
    wr_t w;
    if (sIf.RAM_write_en === 1'b1) begin
      w.cyc = cyc; w.addr = 16'(sIf.RAM_waddr);
      w.r = sIf.red_RAM_wdata; w.g = sIf.green_RAM_wdata; w.b = sIf.blue_RAM_wdata;
      w.done = imgComplete;
      obsQ.push_back(w);
    end
    if (bIf.RAM_write_en === 1'b1) begin
      w.cyc = cyc; w.addr = 16'(bIf.RAM_waddr);
      w.r = bIf.red_RAM_wdata; w.g = bIf.green_RAM_wdata; w.b = bIf.blue_RAM_wdata;
      w.done = bigImgComplete;
      bigObsQ.push_back(w);
    end
  end

  // Reference: word w of channel ch is pixels 4w..4w+3, pixel k in byte k.
  function automatic logic [31:0] expWord(input bit big, input int w, input int ch);
    logic [31:0] v;
    rgb_pixel_t  p;
    logic [7:0]  byteVal;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      p = big ? bigSentQ[4*w+k] : sentQ[4*w+k];
      byteVal = (ch == 0) ? p.r : (ch == 1) ? p.g : p.b;
      v = v + (32'(byteVal) << (8 * k));
    end
    return v;
  endfunction

  task automatic startFrame(input bit withPixel);
    @(posedge wr_clk); #1;
    frameStart = 1'b1;
    sIf.pix_valid = withPixel;
    sIf.pix_data = 24'($urandom);
    @(negedge wr_clk);
    totalChecks++;
    if (sIf.pix_ready !== 1'b0)
      $display("[TB] FAIL ready_on_frame_start: got %b expected 0", sIf.pix_ready);
    else passedChecks++;
    @(posedge wr_clk); #1;
    frameStart = 1'b0;
    sIf.pix_valid = 1'b0;
    sentQ.delete(); hsCyc.delete(); obsQ.delete();
  endtask

  task automatic sendPixels(input int npix, input int bubblePct, input bit usePattern);
    rgb_pixel_t p;
    for (int i = 0; i < npix; i++) begin
      for (int b = 0; b < 3 && $urandom_range(0, 99) < bubblePct; b++) begin
        sIf.pix_valid = 1'b0;
        @(posedge wr_clk); #1;
      end
      if (usePattern) begin
        p.r = 8'(i); p.g = 8'(8'h40 + i); p.b = 8'(8'h80 + i);
      end else p = 24'($urandom);
      sIf.pix_valid = 1'b1;
      sIf.pix_data = p;
      @(negedge wr_clk);
      totalChecks++;
      if (sIf.pix_ready !== 1'b1)
        $display("[TB] FAIL ready_in_capture px%0d: got %b expected 1", i, sIf.pix_ready);
      else passedChecks++;
      sentQ.push_back(p);
      hsCyc.push_back(cyc);
      @(posedge wr_clk); #1;
    end
    sIf.pix_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sIf.pix_valid = 1'b0; sIf.pix_data = '0;
    bIf.pix_valid = 1'b0; bIf.pix_data = '0;
    #3;
    totalChecks++;
    if ({sIf.pix_ready, sIf.RAM_write_en, imgComplete, frameOverrun} !== 4'b0000)
      $display("[TB] FAIL reset_flags: got %b expected 0000",
               {sIf.pix_ready, sIf.RAM_write_en, imgComplete, frameOverrun});
    else passedChecks++;
    totalChecks++;
    if ({sIf.red_RAM_wdata, sIf.green_RAM_wdata, sIf.blue_RAM_wdata} !== 96'd0)
      $display("[TB] FAIL reset_wdata: got %h expected 0",
               {sIf.red_RAM_wdata, sIf.green_RAM_wdata, sIf.blue_RAM_wdata});
    else passedChecks++;
    totalChecks++;
    if (sIf.RAM_waddr !== 2'd0 || pixelsWritten !== 5'd0)
      $display("[TB] FAIL reset_counts: got addr %0d pix %0d expected 0 0", sIf.RAM_waddr, pixelsWritten);
    else passedChecks++;
    @(negedge wr_clk);
    rst_n = 1'b1;
    @(negedge wr_clk);
    totalChecks++;
    if (sIf.pix_ready !== 1'b0)
      $display("[TB] FAIL idle_ready: got %b expected 0", sIf.pix_ready);
    else passedChecks++;
  endtask

  task automatic test_pattern_frame;
    startFrame(1'b0);
    sendPixels(16, 0, 1'b1);
    repeat (3) @(negedge wr_clk);
    totalChecks++;
    if (obsQ.size() != 4) $display("[TB] FAIL pattern_count: got %0d expected 4", obsQ.size());
    else passedChecks++;
    for (int i = 0; i < obsQ.size() && i < 4; i++) begin
      totalChecks++;
      if (obsQ[i].addr !== 16'(i) || obsQ[i].r !== expWord(0, i, 0) || obsQ[i].g !== expWord(0, i, 1) ||
          obsQ[i].b !== expWord(0, i, 2) || obsQ[i].cyc != hsCyc[4*i+3] + 1 || obsQ[i].done !== (i == 3))
        $display("[TB] FAIL pattern_word%0d: got a%0d %h %h %h c%0d d%b expected a%0d %h %h %h c%0d d%b",
                 i, obsQ[i].addr, obsQ[i].r, obsQ[i].g, obsQ[i].b, obsQ[i].cyc, obsQ[i].done,
                 i, expWord(0, i, 0), expWord(0, i, 1), expWord(0, i, 2), hsCyc[4*i+3] + 1, (i == 3));
      else passedChecks++;
    end
    totalChecks++;
    if (obsQ.size() < 1 || obsQ[0].r !== 32'h03020100 || obsQ[0].g !== 32'h43424140 || obsQ[0].b !== 32'h83828180)
      $display("[TB] FAIL pattern_word0_const: got %h %h %h expected 03020100 43424140 83828180",
               obsQ[0].r, obsQ[0].g, obsQ[0].b);
    else passedChecks++;
    totalChecks++;
    if (pixelsWritten !== 5'd16 || imgComplete !== 1'b1 || sIf.pix_ready !== 1'b0)
      $display("[TB] FAIL pattern_end: got pix %0d done %b ready %b expected 16 1 0",
               pixelsWritten, imgComplete, sIf.pix_ready);
    else passedChecks++;
  endtask

  task automatic test_bubbles(input bit usePattern);
    startFrame(1'b0);
    sendPixels(16, 50, usePattern);
    repeat (3) @(negedge wr_clk);
    totalChecks++;
    if (obsQ.size() != 4) $display("[TB] FAIL bubble_count: got %0d expected 4", obsQ.size());
    else passedChecks++;
    for (int i = 0; i < obsQ.size() && i < 4; i++) begin
      totalChecks++;
      if (obsQ[i].addr !== 16'(i) || obsQ[i].r !== expWord(0, i, 0) || obsQ[i].g !== expWord(0, i, 1) ||
          obsQ[i].b !== expWord(0, i, 2) || obsQ[i].cyc != hsCyc[4*i+3] + 1 || obsQ[i].done !== (i == 3))
        $display("[TB] FAIL bubble_word%0d: got a%0d %h %h %h c%0d d%b expected a%0d %h %h %h c%0d d%b",
                 i, obsQ[i].addr, obsQ[i].r, obsQ[i].g, obsQ[i].b, obsQ[i].cyc, obsQ[i].done,
                 i, expWord(0, i, 0), expWord(0, i, 1), expWord(0, i, 2), hsCyc[4*i+3] + 1, (i == 3));
      else passedChecks++;
    end
    totalChecks++;
    if (pixelsWritten !== 5'd16 || imgComplete !== 1'b1)
      $display("[TB] FAIL bubble_end: got pix %0d done %b expected 16 1", pixelsWritten, imgComplete);
    else passedChecks++;
  endtask

  task automatic test_overrun;
    @(posedge wr_clk); #1;
    sIf.pix_valid = 1'b1;
    sIf.pix_data = 24'($urandom);
    @(negedge wr_clk);
    totalChecks++;
    if (sIf.pix_ready !== 1'b0) $display("[TB] FAIL done_ready: got %b expected 0", sIf.pix_ready);
    else passedChecks++;
    @(posedge wr_clk); #1;
    sIf.pix_valid = 1'b0;
    repeat (2) @(negedge wr_clk);
    totalChecks++;
    if (frameOverrun !== 1'b1 || obsQ.size() != 4 || pixelsWritten !== 5'd16 || imgComplete !== 1'b1)
      $display("[TB] FAIL done_overrun: got ovr %b writes %0d pix %0d done %b expected 1 4 16 1",
               frameOverrun, obsQ.size(), pixelsWritten, imgComplete);
    else passedChecks++;
    startFrame(1'b1);
    totalChecks++;
    if (frameOverrun !== 1'b0 || imgComplete !== 1'b0 || pixelsWritten !== 5'd0)
      $display("[TB] FAIL restart_clears: got ovr %b done %b pix %0d expected 0 0 0",
               frameOverrun, imgComplete, pixelsWritten);
    else passedChecks++;
    repeat (2) @(negedge wr_clk);
    totalChecks++;
    if (obsQ.size() != 0 || frameOverrun !== 1'b0)
      $display("[TB] FAIL restart_no_write: got writes %0d ovr %b expected 0 0", obsQ.size(), frameOverrun);
    else passedChecks++;
  endtask

  task automatic test_abort;
    startFrame(1'b0);
    sendPixels(6, 0, 1'b0);
    repeat (2) @(negedge wr_clk);
    totalChecks++;
    if (obsQ.size() != 1 || obsQ[0].addr !== 16'd0 || obsQ[0].r !== expWord(0, 0, 0) || pixelsWritten !== 5'd4)
      $display("[TB] FAIL abort_partial: got writes %0d addr %0d r %h pix %0d expected 1 0 %h 4",
               obsQ.size(), obsQ[0].addr, obsQ[0].r, expWord(0, 0, 0), pixelsWritten);
    else passedChecks++;
    startFrame(1'b0);
    totalChecks++;
    if (pixelsWritten !== 5'd0) $display("[TB] FAIL abort_pix_clear: got %0d expected 0", pixelsWritten);
    else passedChecks++;
    sendPixels(16, 0, 1'b0);
    repeat (3) @(negedge wr_clk);
    totalChecks++;
    if (obsQ.size() != 4) $display("[TB] FAIL abort_count: got %0d expected 4", obsQ.size());
    else passedChecks++;
    for (int i = 0; i < obsQ.size() && i < 4; i++) begin
      totalChecks++;
      if (obsQ[i].addr !== 16'(i) || obsQ[i].r !== expWord(0, i, 0) || obsQ[i].g !== expWord(0, i, 1) ||
          obsQ[i].b !== expWord(0, i, 2) || obsQ[i].cyc != hsCyc[4*i+3] + 1)
        $display("[TB] FAIL abort_word%0d: got a%0d %h %h %h c%0d expected a%0d %h %h %h c%0d",
                 i, obsQ[i].addr, obsQ[i].r, obsQ[i].g, obsQ[i].b, obsQ[i].cyc,
                 i, expWord(0, i, 0), expWord(0, i, 1), expWord(0, i, 2), hsCyc[4*i+3] + 1);
      else passedChecks++;
    end
    totalChecks++;
    if (pixelsWritten !== 5'd16 || imgComplete !== 1'b1)
      $display("[TB] FAIL abort_end: got pix %0d done %b expected 16 1", pixelsWritten, imgComplete);
    else passedChecks++;
  endtask

  task automatic test_reset_mid;
    startFrame(1'b0);
    sendPixels(10, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    totalChecks++;
    if ({sIf.pix_ready, sIf.RAM_write_en, imgComplete, frameOverrun} !== 4'b0000 ||
        sIf.RAM_waddr !== 2'd0 || pixelsWritten !== 5'd0 ||
        {sIf.red_RAM_wdata, sIf.green_RAM_wdata, sIf.blue_RAM_wdata} !== 96'd0)
      $display("[TB] FAIL midreset_outputs: got flags %b addr %0d pix %0d expected 0000 0 0",
               {sIf.pix_ready, sIf.RAM_write_en, imgComplete, frameOverrun}, sIf.RAM_waddr, pixelsWritten);
    else passedChecks++;
    @(posedge wr_clk);
    @(negedge wr_clk);
    rst_n = 1'b1;
    @(posedge wr_clk); #1;
    sIf.pix_valid = 1'b1;
    @(negedge wr_clk);
    totalChecks++;
    if (sIf.pix_ready !== 1'b0) $display("[TB] FAIL midreset_idle_ready: got %b expected 0", sIf.pix_ready);
    else passedChecks++;
    @(posedge wr_clk); #1;
    sIf.pix_valid = 1'b0;
    totalChecks++;
    if (frameOverrun !== 1'b1 || sIf.RAM_write_en !== 1'b0)
      $display("[TB] FAIL idle_overrun: got ovr %b we %b expected 1 0", frameOverrun, sIf.RAM_write_en);
    else passedChecks++;
    startFrame(1'b0);
    sendPixels(16, 0, 1'b0);
    repeat (3) @(negedge wr_clk);
    totalChecks++;
    if (obsQ.size() != 4) $display("[TB] FAIL midreset_count: got %0d expected 4", obsQ.size());
    else passedChecks++;
    for (int i = 0; i < obsQ.size() && i < 4; i++) begin
      totalChecks++;
      if (obsQ[i].addr !== 16'(i) || obsQ[i].r !== expWord(0, i, 0) || obsQ[i].g !== expWord(0, i, 1) ||
          obsQ[i].b !== expWord(0, i, 2) || obsQ[i].done !== (i == 3))
        $display("[TB] FAIL midreset_word%0d: got a%0d %h %h %h d%b expected a%0d %h %h %h d%b",
                 i, obsQ[i].addr, obsQ[i].r, obsQ[i].g, obsQ[i].b, obsQ[i].done,
                 i, expWord(0, i, 0), expWord(0, i, 1), expWord(0, i, 2), (i == 3));
      else passedChecks++;
    end
    totalChecks++;
    if (frameOverrun !== 1'b0 || pixelsWritten !== 5'd16)
      $display("[TB] FAIL midreset_end: got ovr %b pix %0d expected 0 16", frameOverrun, pixelsWritten);
    else passedChecks++;
  endtask

  task automatic test_big_frame;
    int badWords;
    rgb_pixel_t p;
    badWords = 0;
    bigSentQ.delete(); bigObsQ.delete();
    @(posedge wr_clk); #1;
    bigFrameStart = 1'b1;
    @(posedge wr_clk); #1;
    bigFrameStart = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      p = 24'($urandom);
      bIf.pix_valid = 1'b1;
      bIf.pix_data = p;
      bigSentQ.push_back(p);
      @(posedge wr_clk); #1;
    end
    bIf.pix_valid = 1'b0;
    repeat (3) @(negedge wr_clk);
    totalChecks++;
    if (bigObsQ.size() != 1024) $display("[TB] FAIL big_count: got %0d expected 1024", bigObsQ.size());
    else passedChecks++;
    for (int i = 0; i < bigObsQ.size() && i < 1024; i++)
      if (bigObsQ[i].addr !== 16'(i) || bigObsQ[i].r !== expWord(1, i, 0) ||
          bigObsQ[i].g !== expWord(1, i, 1) || bigObsQ[i].b !== expWord(1, i, 2))
        badWords++;
    totalChecks++;
    if (badWords != 0) $display("[TB] FAIL big_words: got %0d bad words expected 0", badWords);
    else passedChecks++;
    totalChecks++;
    if (bigObsQ.size() < 1 || bigObsQ[bigObsQ.size()-1].addr !== 16'h03FF || bigObsQ[bigObsQ.size()-1].done !== 1'b1)
      $display("[TB] FAIL big_last_write: got addr %h done %b expected 03ff 1",
               bigObsQ[bigObsQ.size()-1].addr, bigObsQ[bigObsQ.size()-1].done);
    else passedChecks++;
    totalChecks++;
    if (bigImgComplete !== 1'b1 || bigPixelsWritten !== 13'd4096 || bigFrameOverrun !== 1'b0)
      $display("[TB] FAIL big_end: got done %b pix %0d ovr %b expected 1 4096 0",
               bigImgComplete, bigPixelsWritten, bigFrameOverrun);
    else passedChecks++;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_pattern_frame();
    test_bubbles(1'b1);
    test_bubbles(1'b0);
    test_overrun();
    test_abort();
    test_reset_mid();
    test_big_frame();
    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
